// File: rtl/cereal_rx.sv
// rtl/cereal_rx.sv - 8N1 serial receiver; define CEREAL_RX_PARITY_EN for 8E1 with parity checking
module cereal_rx #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       serialIn,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;
`ifdef CEREAL_RX_PARITY_EN
    localparam logic [2:0] PARITY    = 3'd5;
`endif

    logic [2:0]    state;
    logic          sync1;
    logic          rx_s;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    sh;
    logic          par_bad;

`ifndef CEREAL_RX_PARITY_EN
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            sh        <= '0;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef CEREAL_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            sync1     <= serialIn;
            rx_s      <= sync1;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef CEREAL_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        tick_cnt <= '0;
                        state    <= START;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    // Re-check mid start bit so short low glitches are dropped
                    if (tick_cnt == HALF_M1) begin
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt == FULL_M1) begin
                        tick_cnt <= '0;
                        sh       <= {rx_s, sh[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef CEREAL_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
`ifdef CEREAL_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt == FULL_M1) begin
                        tick_cnt <= '0;
                        par_bad  <= (rx_s != (^sh));
                        state    <= STOP;
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
`endif
                STOP: begin
                    if (tick_cnt == FULL_M1) begin
                        tick_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (par_bad) begin
`ifdef CEREAL_RX_PARITY_EN
                                parity_err <= 1'b1;
`endif
                            end else begin
                                data  <= sh;
                                valid <= 1'b1;
                            end
                        end else begin
                            // Low stop bit: wait for the line to recover before hunting again
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/cereal_rx.md
# cereal_rx

Serial-to-parallel receiver for the board's one-wire serial link: the receive-side counterpart of the `cereal` transmitter. It samples an asynchronous idle-high line and recovers 8N1 frames: one low start bit, 8 data bits LSB first, and one high stop bit. Each good byte is presented on `data` with a one-cycle `valid` strobe. It sits between the `serialIn` pin and the consumers in the control system (tweetboard store path, debug LEDs).

## Interface
- `CLKS_PER_BIT`, default 10416: sysclk cycles per bit (100 MHz / 9600 baud); minimum legal value 4.
- `sysclk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `serialIn`  in  1  asynchronous serial line, idle high.
- `data`  out  8  last correctly received byte; holds until the next good frame.
- `valid`  out  1  one-cycle pulse, coincident with a `data` update.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `parity_err`  out  1  one-cycle pulse on parity mismatch (see Configuration).
- `busy`  out  1  high in every state except IDLE.

## Operation
- Input sync: two-flop synchronizer on `serialIn` produces `rx_s`. Both flops reset to 1. All decisions use `rx_s`.
- Bit counter `tick_cnt` is `$clog2(CLKS_PER_BIT)` bits wide. Bit index `bit_idx` is 3 bits. Shift register `sh` is 8 bits.
- States:
  - IDLE: on `rx_s`==0, clear `tick_cnt` and go to START.
  - START: when `tick_cnt`==CLKS_PER_BIT/2-1 (mid start bit), re-sample `rx_s`. If it is 0, clear the counter and `bit_idx` and go to DATA. If it is 1, treat as a glitch and go to IDLE with no strobe.
  - DATA: when `tick_cnt`==CLKS_PER_BIT-1 (mid bit), shift `rx_s` into `sh[7]` (right shift, LSB first) and clear the counter. After `bit_idx`==7, go to PARITY if parity is enabled, otherwise STOP.
  - PARITY (macro only): at mid bit, compare `rx_s` with the even parity (XOR) of `sh`, record the mismatch, then go to STOP.
  - STOP: at mid stop bit:
    - If `rx_s`==1 and parity is OK: load `data`<=`sh`, pulse `valid`, go to IDLE.
    - If `rx_s`==1 and parity is bad: pulse `parity_err`, leave `data` unchanged, go to IDLE.
    - If `rx_s`==0: pulse `frame_err`, leave `data` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This prevents a break or stuck-low line from being re-read as a start bit.
- `frame_err` takes priority over `parity_err`; only one strobe fires per frame.
- The next start bit is accepted from the cycle after the return to IDLE. Because sampling happens mid stop bit, back-to-back frames are received without loss.
- `serialIn` changes during reset are ignored; reset mid-frame discards the partial byte.

## Timing
- Reset values: `data`=8'h00, `valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, state IDLE, synchronizer flops 1.
- Falling edge at pin to START entry: 2 sync cycles plus 1.
- Latency from the start-bit falling edge at the pin to the `valid` pulse: 2 + 1 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles (+CLKS_PER_BIT with parity), within ±1 cycle.
- `valid`, `frame_err` and `parity_err` are registered, exactly one cycle wide, and never overlap.
- `busy` rises the cycle after START entry and falls the cycle `valid` or `parity_err` pulses, or on exit from WAIT_HIGH.

## Configuration
- `CEREAL_RX_PARITY_EN` defined:
  - Frame is 8E1; the PARITY state exists.
  - `parity_err` is driven as described in Operation.
  - Frame length is 11 bits.
- `CEREAL_RX_PARITY_EN` undefined:
  - Frame is 8N1; the PARITY state and its logic are not compiled.
  - `parity_err` is tied to 0.

## Test plan
(all with CLKS_PER_BIT=16)
- Reset then idle line for 200 cycles -> all outputs 0, `data`=8'h00, no strobes.
- Send 8'hA5, 8N1 -> exactly one `valid` pulse with `data`=8'hA5, about 154 cycles after the start edge; `busy` high only during the frame.
- Send 8'h3C then 8'hC3 back to back with no idle gap -> two `valid` pulses, `data`=8'h3C then 8'hC3; no `frame_err`.
- 4-cycle low glitch on idle line -> return to IDLE, no strobe; a following 8'h55 frame is received correctly.
- Send 8'h81 with the stop bit forced low, line held low 40 more cycles -> `frame_err` pulse, `data` keeps its previous value, no start detected until the line goes high; the next frame 8'h12 is received.
- With `CEREAL_RX_PARITY_EN`: 8'h07 sent with parity bit 1 -> `valid` with `data`=8'h07. Same byte with parity bit 0 -> `parity_err` pulse and `data` unchanged. Reset asserted mid DATA -> outputs return to reset values on the next edge.
